// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared keypad definitions: matrix geometry and one-hot key codes (bit index = row*4+col).
package keypad_matrix_scanner_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_BITS = KEY_ROWS * KEY_COLS;

  localparam logic [KEY_BITS-1:0] KEY_NONE = '0;
  localparam logic [KEY_BITS-1:0] KEY_R0C0 = 16'h0001;
  localparam logic [KEY_BITS-1:0] KEY_R0C1 = 16'h0002;
  localparam logic [KEY_BITS-1:0] KEY_R0C2 = 16'h0004;
  localparam logic [KEY_BITS-1:0] KEY_R0C3 = 16'h0008;
  localparam logic [KEY_BITS-1:0] KEY_R1C0 = 16'h0010;
  localparam logic [KEY_BITS-1:0] KEY_R1C1 = 16'h0020;
  localparam logic [KEY_BITS-1:0] KEY_R1C2 = 16'h0040;
  localparam logic [KEY_BITS-1:0] KEY_R1C3 = 16'h0080;
  localparam logic [KEY_BITS-1:0] KEY_R2C0 = 16'h0100;
  localparam logic [KEY_BITS-1:0] KEY_R2C1 = 16'h0200;
  localparam logic [KEY_BITS-1:0] KEY_R2C2 = 16'h0400;
  localparam logic [KEY_BITS-1:0] KEY_R2C3 = 16'h0800;
  localparam logic [KEY_BITS-1:0] KEY_R3C0 = 16'h1000;
  localparam logic [KEY_BITS-1:0] KEY_R3C1 = 16'h2000;
  localparam logic [KEY_BITS-1:0] KEY_R3C2 = 16'h4000;
  localparam logic [KEY_BITS-1:0] KEY_R3C3 = 16'h8000;

  // True when exactly one key is pressed in a frame.
  function automatic logic is_single_key(input logic [KEY_BITS-1:0] f);
    return (f != KEY_NONE) && ((f & (f - 1'b1)) == KEY_NONE);
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_frame_debounce.sv
// Per-frame classification and debounce: rejects multi-key frames and requires
// DEBOUNCE_SCANS identical candidates before the registered key code changes.
module keypad_frame_debounce
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_end,
  input  logic [KEY_BITS-1:0] frame_bits,
  output logic [KEY_BITS-1:0] onehot,
  output logic                key_valid,
  output logic                key_pulse
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [KEY_BITS-1:0] cand;
  logic [KEY_BITS-1:0] prev_cand;
  logic [SW-1:0]       stab;
  logic [SW-1:0]       stab_next;

  always_comb begin
    cand = is_single_key(frame_bits) ? frame_bits : KEY_NONE;
    if (cand != prev_cand)
      stab_next = SW'(1);
    else if (stab >= SW'(DEBOUNCE_SCANS))
      stab_next = SW'(DEBOUNCE_SCANS);
    else
      stab_next = stab + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cand <= KEY_NONE;
      stab      <= '0;
      onehot    <= KEY_NONE;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (frame_end) begin
        stab      <= stab_next;
        prev_cand <= cand;
        // A switch A->B lands directly on B; releasing to none never pulses.
        if (stab_next == SW'(DEBOUNCE_SCANS) && cand != onehot) begin
          onehot    <= cand;
          key_valid <= (cand != KEY_NONE);
          key_pulse <= (cand != KEY_NONE);
        end
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: column synchronizer, row/dwell counters and frame
// register, feeding the frame debouncer that produces the one-hot key code.
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_COLS-1:0] col_in,
  output logic [KEY_ROWS-1:0] row_out,
  output logic [KEY_BITS-1:0] onehot,
  output logic                key_valid,
  output logic                key_pulse
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [KEY_COLS-1:0] col_meta;
  logic [KEY_COLS-1:0] col_sync;
  logic [1:0]          row_idx;
  logic [1:0]          row_next;
  logic [DW-1:0]       dwell;
  logic [11:0]         frame;
  logic                sample;
  logic                frame_end;
  logic [KEY_BITS-1:0] frame_full;

  assign sample     = (dwell == DW'(SCAN_DIV - 1));
  assign frame_end  = sample && (row_idx == 2'd3);
  assign row_next   = row_idx + 2'd1;
  // Row 3 is never stored: it is fed straight from the synchronizer on the frame-end cycle.
  assign frame_full = {~col_sync, frame};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= '0;
      row_out <= 4'b1110;
      frame   <= '0;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_next;
      row_out <= ~(4'b0001 << row_next);
      case (row_idx)
        2'd0:    frame[3:0]  <= ~col_sync;
        2'd1:    frame[7:4]  <= ~col_sync;
        2'd2:    frame[11:8] <= ~col_sync;
        default: ;
      endcase
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  keypad_frame_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end),
    .frame_bits(frame_full),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner with a behavioural keypad matrix and
// a queue of expected key codes consumed on every key_pulse.
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;
  logic [15:0] keys = '0;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  keypad_matrix_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its column to its row; rows are active-low.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && key_pulse === 1'b1) begin
      logic [15:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: onehot=%h, no pulse expected", onehot);
      end else begin
        e = exp_q.pop_front();
        if (onehot !== e) begin
          bad++;
          $display("FAIL pulse_code: got %h want %h", onehot, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_frame_start();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev  = row_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && row_out == 4'b1110) found = 1;
      prev = row_out;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL frame_sync: row_out=%b, no 0111->1110 within 40 cycles", row_out);
    end
  endtask

  task automatic test_reset();
    logic [3:0] seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    total += 4;
    if (row_out !== 4'b1110) begin bad++; $display("FAIL rst_row: got %b want 1110", row_out); end
    if (onehot !== 16'h0000) begin bad++; $display("FAIL rst_onehot: got %h want 0000", onehot); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
    if (key_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %b want 0", key_pulse); end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      total++;
      if (row_out !== seq[(k/4)%4]) begin
        bad++;
        $display("FAIL row_scan[%0d]: got %b want %b", k, row_out, seq[(k/4)%4]);
      end
    end
  endtask

  task automatic test_steady_press();
    int pulses;
    wait_frame_start();
    keys = 16'h0040;
    exp_q.push_back(16'h0040);
    repeat (47) @(negedge clk);
    total++;
    if (onehot !== 16'h0000) begin bad++; $display("FAIL press_early: got %h want 0000", onehot); end
    @(negedge clk);
    total += 3;
    if (onehot !== 16'h0040) begin bad++; $display("FAIL press_code: got %h want 0040", onehot); end
    if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid: got %b want 1", key_valid); end
    if (key_pulse !== 1'b1) begin bad++; $display("FAIL press_pulse: got %b want 1", key_pulse); end
    @(negedge clk);
    total++;
    if (key_pulse !== 1'b0) begin bad++; $display("FAIL press_pulse_width: got %b want 0", key_pulse); end
    pulses = 0;
    repeat (96) begin @(negedge clk); if (key_pulse) pulses++; end
    total += 2;
    if (pulses != 0) begin bad++; $display("FAIL hold_repeat: got %0d pulses want 0", pulses); end
    if (onehot !== 16'h0040) begin bad++; $display("FAIL hold_code: got %h want 0040", onehot); end
  endtask

  task automatic test_reset_mid();
    wait_frame_start();
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total += 4;
    if (row_out !== 4'b1110) begin bad++; $display("FAIL mid_rst_row: got %b want 1110", row_out); end
    if (onehot !== 16'h0000) begin bad++; $display("FAIL mid_rst_onehot: got %h want 0000", onehot); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", key_valid); end
    if (key_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_pulse: got %b want 0", key_pulse); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'h0040);
    repeat (47) @(negedge clk);
    total++;
    if (onehot !== 16'h0000) begin bad++; $display("FAIL mid_rst_early: got %h want 0000", onehot); end
    @(negedge clk);
    total += 2;
    if (onehot !== 16'h0040) begin bad++; $display("FAIL mid_rst_return: got %h want 0040", onehot); end
    if (key_pulse !== 1'b1) begin bad++; $display("FAIL mid_rst_pulse_back: got %b want 1", key_pulse); end
  endtask

  task automatic test_bounce();
    int pulses, nz;
    keys = '0;
    repeat (80) @(negedge clk);
    total++;
    if (onehot !== 16'h0000) begin bad++; $display("FAIL settle: got %h want 0000", onehot); end
    wait_frame_start();
    pulses = 0;
    nz     = 0;
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (16) begin
        @(negedge clk);
        if (key_pulse) pulses++;
        if (onehot !== 16'h0000) nz++;
      end
    end
    keys = '0;
    repeat (32) begin @(negedge clk); if (key_pulse) pulses++; end
    total += 2;
    if (pulses != 0) begin bad++; $display("FAIL bounce_pulse: got %0d pulses want 0", pulses); end
    if (nz != 0) begin bad++; $display("FAIL bounce_code: onehot nonzero for %0d cycles want 0", nz); end
  endtask

  task automatic test_ghosting();
    int nz;
    wait_frame_start();
    keys = 16'h0801;
    nz   = 0;
    repeat (96) begin @(negedge clk); if (onehot !== 16'h0000) nz++; end
    total++;
    if (nz != 0) begin bad++; $display("FAIL ghost_reject: onehot nonzero for %0d cycles want 0", nz); end
    keys = 16'h0001;
    exp_q.push_back(16'h0001);
    repeat (47) @(negedge clk);
    total++;
    if (onehot !== 16'h0000) begin bad++; $display("FAIL ghost_early: got %h want 0000", onehot); end
    @(negedge clk);
    total += 2;
    if (onehot !== 16'h0001) begin bad++; $display("FAIL ghost_single: got %h want 0001", onehot); end
    if (key_pulse !== 1'b1) begin bad++; $display("FAIL ghost_pulse: got %b want 1", key_pulse); end
  endtask

  task automatic test_release();
    keys = '0;
    repeat (47) @(negedge clk);
    total++;
    if (onehot !== 16'h0001) begin bad++; $display("FAIL release_early: got %h want 0001", onehot); end
    @(negedge clk);
    total += 3;
    if (onehot !== 16'h0000) begin bad++; $display("FAIL release_code: got %h want 0000", onehot); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", key_valid); end
    if (key_pulse !== 1'b0) begin bad++; $display("FAIL release_pulse: got %b want 0", key_pulse); end
  endtask

  task automatic test_switch();
    int off;
    keys = 16'h0001;
    exp_q.push_back(16'h0001);
    repeat (48) @(negedge clk);
    total++;
    if (onehot !== 16'h0001) begin bad++; $display("FAIL switch_first: got %h want 0001", onehot); end
    keys = 16'h2000;
    exp_q.push_back(16'h2000);
    off = 0;
    repeat (47) begin @(negedge clk); if (onehot !== 16'h0001) off++; end
    total++;
    if (off != 0) begin bad++; $display("FAIL switch_hold: onehot left 0001 for %0d cycles want 0", off); end
    @(negedge clk);
    total += 3;
    if (onehot !== 16'h2000) begin bad++; $display("FAIL switch_code: got %h want 2000", onehot); end
    if (key_valid !== 1'b1) begin bad++; $display("FAIL switch_valid: got %b want 1", key_valid); end
    if (key_pulse !== 1'b1) begin bad++; $display("FAIL switch_pulse: got %b want 1", key_pulse); end
  endtask

  initial begin
    test_reset();
    test_steady_press();
    test_reset_mid();
    test_bounce();
    test_ghosting();
    test_release();
    test_switch();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending codes want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
